// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, NOP and fetch FSM states.
// Imported by the fetch stage and the instruction decoder.
package riscv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns PC, old_pc and IR; one imem request per fetch.
// Optional misaligned-fetch trap: define FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_start,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic            instr_valid,
  output logic            busy,
  output logic            fetch_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] fa;
  logic            misalign;

  assign fa = pc_we ? pc_next : pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;

  assign misalign = |fa[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state == IDLE) && fetch_start && misalign;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      old_pc      <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_start) begin
            pc <= fa;
            if (!misalign) begin
              old_pc <= fa;
              state  <= REQ;
            end
          end else if (pc_we) begin
            pc <= pc_next;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            pc          <= pc + XLEN'(4);
            instr_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address comes straight from PC, which cannot move while in REQ.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign busy           = (state != IDLE);
  assign op             = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: request and response queues.
// Checks both builds of FETCH_MISALIGN_CHECK_EN.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] old_pc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic [6:0]  op;
  logic        instr_valid;
  logic        busy;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int iv_cnt  = 0;
  int ff_cnt  = 0;
  logic prev_iv = 1'b0;
  logic prev_ff = 1'b0;

  logic [31:0] req_q[$];
  rsp_t        rsp_q[$];
  rsp_t        e;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_start    (fetch_start),
    .pc_we          (pc_we),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .old_pc         (old_pc),
    .instr          (instr),
    .op             (op),
    .instr_valid    (instr_valid),
    .busy           (busy),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: sample outputs mid-cycle, pop scoreboard entries.
  always @(negedge clk) begin
    if (imem_req_valid) begin
      if (req_q.size() == 0) begin
        chk("unexp_req", {31'd0, imem_req_valid}, 32'd0);
      end else begin
        chk("req_addr", imem_req_addr, req_q[0]);
        chk("req_pc", pc, req_q[0]);
        if (imem_req_ready) void'(req_q.pop_front());
      end
    end
    if (instr_valid) begin
      chk("iv_pulse", {31'd0, prev_iv}, 32'd0);
      iv_cnt++;
      if (rsp_q.size() == 0) begin
        chk("unexp_iv", {31'd0, instr_valid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("instr", instr, e.instr);
        chk("pc_after", pc, e.pc);
        chk("old_pc", old_pc, e.old_pc);
        chk("op", {25'd0, op}, {25'd0, e.instr[6:0]});
      end
    end
    if (fetch_fault) begin
      chk("ff_pulse", {31'd0, prev_ff}, 32'd0);
      ff_cnt++;
    end
    prev_iv = instr_valid;
    prev_ff = fetch_fault;
  end

  task automatic fetch(input logic        we,
                       input logic [31:0] nxt,
                       input logic [31:0] a,
                       input int          rdy,
                       input int          rsp,
                       input logic [31:0] d,
                       input logic        glitch);
    int   iv0;
    rsp_t x;
    iv0 = iv_cnt;
    req_q.push_back(a);
    x.instr  = d;
    x.pc     = a + 32'd4;
    x.old_pc = a;
    rsp_q.push_back(x);
    fetch_start = 1'b1;
    pc_we       = we;
    pc_next     = nxt;
    tick();
    fetch_start = 1'b0;
    pc_we       = 1'b0;
    chk("busy_req", {31'd0, busy}, 32'd1);
    tick(rdy);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 1; i < rsp; i++) begin
      if (glitch) begin
        fetch_start = 1'b1;
        pc_we       = 1'b1;
        pc_next     = 32'h0000_0040;
      end
      tick();
      fetch_start = 1'b0;
      pc_we       = 1'b0;
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick();
    imem_rsp_valid = 1'b0;
    tick(2);
    chk("iv_count", iv_cnt - iv0, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int iv0;
    int ff0;
    rst_n          = 1'b0;
    fetch_start    = 1'b0;
    pc_we          = 1'b0;
    pc_next        = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    tick(2);
    rst_n = 1'b1;

    // 1: reset values after idling
    tick(5);
    chk("rst_pc", pc, 32'h0);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_op", {25'd0, op}, 32'h13);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);

    // 2: PC load then fetch with slow ready
    pc_we   = 1'b1;
    pc_next = 32'h0000_0100;
    tick();
    pc_we = 1'b0;
    chk("pc_load", pc, 32'h0000_0100);
    chk("busy_pc_load", {31'd0, busy}, 32'd0);
    fetch(1'b0, 32'h0, 32'h0000_0100, 3, 2, 32'h00A0_0093, 1'b0);

    // 3: redirect-and-fetch
    fetch(1'b1, 32'h0000_0200, 32'h0000_0200, 0, 1, 32'h0010_8133, 1'b0);

    // 4: wrap and ignored controls during WAIT
    pc_we   = 1'b1;
    pc_next = 32'hFFFF_FFFC;
    tick();
    pc_we = 1'b0;
    fetch(1'b0, 32'h0, 32'hFFFF_FFFC, 1, 3, 32'h0000_006F, 1'b1);
    tick(3);
    chk("wrap_pc_hold", pc, 32'h0);

    // 5: reset during WAIT, late response dropped
    iv0         = iv_cnt;
    req_q.push_back(32'h0000_0300);
    pc_we       = 1'b1;
    pc_next     = 32'h0000_0300;
    fetch_start = 1'b1;
    tick();
    pc_we       = 1'b0;
    fetch_start = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    tick(2);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_old_pc", old_pc, 32'h0);
    chk("mid_rst_iv", iv_cnt - iv0, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);

    // 6: misaligned redirect-and-fetch
`ifdef FETCH_MISALIGN_CHECK_EN
    ff0         = ff_cnt;
    pc_we       = 1'b1;
    pc_next     = 32'h0000_0102;
    fetch_start = 1'b1;
    tick();
    pc_we       = 1'b0;
    fetch_start = 1'b0;
    chk("mis_busy", {31'd0, busy}, 32'd0);
    tick(2);
    chk("mis_fault", ff_cnt - ff0, 32'd1);
    chk("mis_pc", pc, 32'h0000_0102);
    chk("mis_old_pc", old_pc, 32'h0);
    chk("mis_busy2", {31'd0, busy}, 32'd0);
`else
    ff0 = ff_cnt;
    fetch(1'b1, 32'h0000_0102, 32'h0000_0102, 1, 1, 32'h0000_0037, 1'b0);
    chk("no_fault", ff_cnt - ff0, 32'd0);
`endif

    tick(2);
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
